sipo_rx: RTL and testbench

Serial-in, parallel-out receiver. It is the receiving end of the 4-bit PISO serial link: it samples one bit per enabled clock, MSB first, and assembles WIDTH bits into a word. It presents each completed word on a holding register with a valid/ready handshake and flags words lost to backpressure. It sits between the serial line and the parallel consumer logic.

---
 rtl/sipo_rx.sv | 73 +++++++
 tb/tb_sipo_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: assembles WIDTH bits, MSB first, into a handshaked holding register.
// Latency: word visible on pout/pout_valid the cycle after its last bit is sampled.
// Backpressure: a word completing while the holding register is full and not being accepted is dropped; sticky overrun is set.
module sipo_rx #(
    parameter int WIDTH = 4,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             clr,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic [CW-1:0]    bit_cnt,
    output logic             overrun,
    input  logic             overrun_clr
);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] next_word;
    logic             strobe;
    logic             last_bit;
    logic             complete;
    logic             load;
    logic             drop;

    // clr outranks the strobe, so an aborted edge never samples or completes
    assign strobe    = sin_en && !clr;
    assign last_bit  = (bit_cnt == CW'(WIDTH - 1));
    assign complete  = strobe && last_bit;
    assign next_word = {shreg[WIDTH-2:0], sin};
    assign load      = complete && (!pout_valid || pout_ready);
    assign drop      = complete && pout_valid && !pout_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clr) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (sin_en) begin
            shreg   <= next_word;
            bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pout       <= '0;
            pout_valid <= 1'b0;
        end else if (load) begin
            pout       <= next_word;
            pout_valid <= 1'b1;
        end else if (pout_valid && pout_ready) begin
            pout_valid <= 1'b0;
        end
    end

    // a drop on the same edge as overrun_clr keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: directed scenarios with literal expectations plus randomized traffic,
// every cycle compared against a queue-based word model.
module tb_sipo_rx;
    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          sin, sin_en, clr, pout_ready, overrun_clr;
    logic [W-1:0]  pout;
    logic          pout_valid, overrun;
    logic [CW-1:0] bit_cnt;

    int total = 0;
    int bad   = 0;

    int           m_bits[$];
    logic [W-1:0] m_pout;
    bit           m_valid, m_ovr;

    sipo_rx #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .clr(clr),
        .pout(pout), .pout_valid(pout_valid), .pout_ready(pout_ready),
        .bit_cnt(bit_cnt), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_pout  = '0;
        m_valid = 0;
        m_ovr   = 0;
    endtask

    // Word value is rebuilt from the received bit list, first bit most significant.
    task automatic model_edge(input bit en, input bit s, input bit c, input bit r, input bit oc);
        bit           comp = 0;
        logic [W-1:0] w = '0;
        bit           old_valid = m_valid;
        if (c) m_bits.delete();
        else if (en) begin
            m_bits.push_back(int'(s));
            if (m_bits.size() == W) begin
                for (int i = 0; i < W; i++) w = W'(w * 2 + m_bits[i]);
                comp = 1;
                m_bits.delete();
            end
        end
        if (comp && (!old_valid || r)) begin
            m_pout  = w;
            m_valid = 1;
        end else if (old_valid && r) begin
            m_valid = 0;
        end
        if (comp && old_valid && !r) m_ovr = 1;
        else if (oc) m_ovr = 0;
    endtask

    task automatic compare_all();
        check("pout", pout, m_pout);
        check("pout_valid", pout_valid, m_valid);
        check("bit_cnt", bit_cnt, m_bits.size());
        check("overrun", overrun, m_ovr);
    endtask

    task automatic step(input bit en, input bit s, input bit c, input bit r, input bit oc);
        sin_en = en; sin = s; clr = c; pout_ready = r; overrun_clr = oc;
        @(posedge clk);
        model_edge(en, s, c, r, oc);
        #1;
        compare_all();
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit rdy_last, input bit oc_last);
        logic [W-1:0] v;
        v = w;
        for (int i = W - 1; i >= 0; i--)
            step(1, v[i], 0, (i == 0) ? rdy_last : 1'b0, (i == 0) ? oc_last : 1'b0);
    endtask

    task automatic idle(input bit r);
        step(0, 0, 0, r, 0);
    endtask

    initial begin
        rst = 1; sin = 0; sin_en = 0; clr = 0; pout_ready = 0; overrun_clr = 0;
        model_reset();
        #3;
        check("reset_pout", pout, 0);
        check("reset_valid", pout_valid, 0);
        check("reset_bit_cnt", bit_cnt, 0);
        check("reset_overrun", overrun, 0);
        @(negedge clk);
        rst = 0;

        // basic word 1011 with bit_cnt stepping 1,2,3,0
        step(1, 1, 0, 0, 0); check("basic_cnt1", bit_cnt, 1);
        step(1, 0, 0, 0, 0); check("basic_cnt2", bit_cnt, 2);
        step(1, 1, 0, 0, 0); check("basic_cnt3", bit_cnt, 3);
        check("basic_not_valid_yet", pout_valid, 0);
        step(1, 1, 0, 0, 0); check("basic_cnt0", bit_cnt, 0);
        check("basic_pout", pout, 4'hB);
        check("basic_valid", pout_valid, 1);
        idle(1);
        check("basic_consumed", pout_valid, 0);

        // gapped strobes 0,1,1,0 with three idle cycles between
        step(1, 0, 0, 0, 0);
        for (int b = 1; b < 4; b++) begin
            for (int g = 0; g < 3; g++) begin
                idle(0);
                check("gap_hold_cnt", bit_cnt, b);
            end
            step(1, (b == 3) ? 1'b0 : 1'b1, 0, 0, 0);
        end
        check("gap_pout", pout, 4'h6);
        check("gap_valid", pout_valid, 1);
        idle(1);

        // overrun, with overrun_clr losing to a simultaneous set
        send_word(4'hA, 0, 0);
        send_word(4'h5, 0, 1);
        check("ovr_pout_kept", pout, 4'hA);
        check("ovr_flag", overrun, 1);
        check("ovr_valid", pout_valid, 1);
        step(0, 0, 0, 1, 1);
        check("ovr_accept_valid", pout_valid, 0);
        check("ovr_cleared", overrun, 0);

        // accept and complete on the same edge
        send_word(4'h3, 0, 0);
        check("acc_first", pout, 4'h3);
        send_word(4'hC, 1, 0);
        check("acc_pout", pout, 4'hC);
        check("acc_valid", pout_valid, 1);
        check("acc_no_ovr", overrun, 0);
        idle(1);

        // clr mid-word discards the partial word and its own strobe
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);
        check("clr_cnt", bit_cnt, 0);
        check("clr_keeps_valid", pout_valid, 0);
        send_word(4'h1, 0, 0);
        check("clr_pout", pout, 4'h1);
        check("clr_valid", pout_valid, 1);

        // async reset between edges, mid-word with a valid word held
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        #3 rst = 1;
        #1;
        check("arst_pout", pout, 0);
        check("arst_valid", pout_valid, 0);
        check("arst_cnt", bit_cnt, 0);
        check("arst_ovr", overrun, 0);
        model_reset();
        #2 rst = 0;
        send_word(4'hC, 0, 0);
        check("arst_after_pout", pout, 4'hC);
        check("arst_after_valid", pout_valid, 1);
        idle(1);

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 24) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
